vending_machine_multi: RTL and testbench
========================================

// Module: vending_machine_multi
// PURPOSE
//  Parametrised successor of the single-price vending FSM: N drink slots, each with its own price and stock counter.
//  Supports saturating coin credit, cancel/refund, and auto change return. Vend and change use valid/ready handshakes.
//  Sits between the coin acceptor / keypad front end and the dispenser and change-hopper actuators.
// PARAMETERS
//  N_DRINKS    4        number of drink slots (1..16)
//  SEL_W       2        selection code width, >= clog2(N_DRINKS)
//  COIN_W      2        coin value width (value in rupees)
//  BAL_W       4        balance/price width
//  MAX_BAL     15       credit ceiling, <= 2**BAL_W-1
//  PRICES      16'h3333 packed prices, BAL_W bits per slot, slot 0 in LSBs; a price of 0 is illegal
//  STOCK_W     4        per-slot stock counter width
//  STOCK_INIT  8        stock loaded at reset, <= 2**STOCK_W-1
//  AUTO_CHANGE 1        1: return remaining credit after each vend; 0: keep credit
// PORTS
//  clk            in  1          rising-edge clock
//  reset_n        in  1          asynchronous active-low reset
//  coin_valid     in  1          coin present this cycle
//  coin_value     in  COIN_W     value of the coin
//  sel_valid      in  1          selection strobe
//  sel            in  SEL_W      drink code
//  cancel         in  1          refund request
//  restock_valid  in  1          restock strobe
//  restock_id     in  SEL_W      slot to refill to STOCK_INIT
//  dispense_valid out 1          vend request to dispenser
//  dispense_id    out SEL_W      slot being vended
//  dispense_ready in  1          dispenser accepts
//  change_valid   out 1          change request to hopper
//  change_amount  out BAL_W      amount to return
//  change_ready   in  1          hopper accepts
//  balance        out BAL_W      current credit
//  coin_reject    out 1          1-cycle pulse: coin not credited
//  sel_err        out 2          1-cycle code: 01 sold out, 10 insufficient credit, 11 invalid/busy
//  sold_out       out N_DRINKS   bit i = stock[i]==0
// BEHAVIOUR
//  Reset: state=IDLE; balance=0; stock[*]=STOCK_INIT; all valid, pulse, id and amount outputs = 0.
//  FSM: IDLE -> VEND -> (CHANGE | IDLE); IDLE -> CHANGE on cancel. State 2'b11 is unused and recovers to IDLE.
//  IDLE coin: if balance+coin_value <= MAX_BAL, add it next cycle. Otherwise pulse coin_reject and leave balance unchanged. Sum is computed BAL_W+1 wide.
//  IDLE sel, checked in priority order:
//   - sel >= N_DRINKS -> sel_err=11
//   - stock==0 -> sel_err=01
//   - balance < price -> sel_err=10
//   - otherwise: balance -= price, stock -= 1, dispense_id=sel, dispense_valid=1 from the next cycle, go to VEND.
//  Same-cycle coin+sel in IDLE: sel is evaluated against the pre-coin balance. The coin is credited after the price is deducted, subject to MAX_BAL.
//  IDLE cancel: balance>0 -> go to CHANGE with change_amount=balance. balance==0 -> ignored. Cancel has priority over sel; a sel in the same cycle is dropped with sel_err=11.
//  VEND: hold dispense_valid and dispense_id stable until dispense_ready is sampled high. On that edge drop valid, then:
//   - go to CHANGE if AUTO_CHANGE and balance>0
//   - otherwise go to IDLE.
//  CHANGE: change_amount is latched on entry. Hold change_valid until change_ready; on that edge set balance=0, drop valid, go to IDLE.
//  Outside IDLE: coin_valid -> coin_reject; sel_valid -> sel_err=11; cancel ignored.
//  Restock is accepted in any state and sets stock[restock_id]=STOCK_INIT. An out-of-range id is ignored.
//  Restock same cycle as a vend decrement of the same slot: restock wins.
//  sold_out and balance are registered-state views (combinational from state registers).
//  Reset mid-VEND/CHANGE aborts the transaction immediately; credit and stock are reinitialised.
// TESTING
//  1 Coins 2,2 then sel=1 (price 3) -> balance 4 then 1; dispense_valid/id=1 until ready; change 1 returned; balance 0.
//  2 balance=14, coin 2 -> coin_reject pulse, balance stays 14; coin 1 -> balance 15.
//  3 Slot 2 stock 1: vend it, then sel=2 -> sel_err=01, sold_out[2]=1; restock_id=2 -> sold_out[2]=0.
//  4 balance 2, sel=0 -> sel_err=10; cancel -> change_valid, amount 2; ready held low 5 cycles -> outputs stable, then ready -> balance 0.
//  5 Coin+sel same cycle at balance 3 (coin 2) -> vend, balance 2; coin during VEND -> coin_reject.
//  6 reset_n low mid-VEND -> outputs 0 asynchronously, stock=STOCK_INIT; sel=3 (N_DRINKS=3 build) -> sel_err=11.

Source files
------------

// File: rtl/vending_machine_multi.sv
// ---------------------------------------------------------------------------
// vending_machine_multi
//   Multi-slot vending controller. It sits between the coin acceptor / keypad
//   front end and the dispenser and change-hopper actuators. Each slot has its
//   own price and stock counter. Credit saturates at MAX_BAL, and a coin that
//   would overflow the credit is rejected. Cancel refunds the credit. Remaining
//   credit can be returned automatically after a vend. The vend and change
//   requests use valid/ready handshakes.
//
// Ports
//   clk, reset_n                   rising-edge clock, async active-low reset
//   coin_valid, coin_value         coin inserted this cycle and its value
//   sel_valid, sel                 drink selection strobe and slot code
//   cancel                         refund request
//   restock_valid, restock_id      refill one slot to STOCK_INIT
//   dispense_valid/id/ready        vend handshake toward the dispenser
//   change_valid/amount/ready      refund handshake toward the change hopper
//   balance                        current credit
//   coin_reject                    1-cycle pulse: coin was not credited
//   sel_err                        1-cycle code: 01 sold out,
//                                  10 insufficient credit, 11 invalid/busy
//   sold_out                       bit i set when slot i has no stock
// ---------------------------------------------------------------------------
module vending_machine_multi #(
  parameter int N_DRINKS    = 4,
  parameter int SEL_W       = 2,
  parameter int COIN_W      = 2,
  parameter int BAL_W       = 4,
  parameter int MAX_BAL     = 15,
  parameter logic [N_DRINKS*BAL_W-1:0] PRICES = {N_DRINKS{BAL_W'(3)}},
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 8,
  parameter int AUTO_CHANGE = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_value,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  input  logic                restock_valid,
  input  logic [SEL_W-1:0]    restock_id,
  output logic                dispense_valid,
  output logic [SEL_W-1:0]    dispense_id,
  input  logic                dispense_ready,
  output logic                change_valid,
  output logic [BAL_W-1:0]    change_amount,
  input  logic                change_ready,
  output logic [BAL_W-1:0]    balance,
  output logic                coin_reject,
  output logic [1:0]          sel_err,
  output logic [N_DRINKS-1:0] sold_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    VEND   = 2'b01,
    CHANGE = 2'b10
  } state_t;

  state_t                      state_reg, state_next;
  logic [BAL_W-1:0]            balance_reg, balance_next;
  logic                        dispense_valid_reg, dispense_valid_next;
  logic [SEL_W-1:0]            dispense_id_reg, dispense_id_next;
  logic                        change_valid_reg, change_valid_next;
  logic [BAL_W-1:0]            change_amount_reg, change_amount_next;
  logic                        coin_reject_reg, coin_reject_next;
  logic [1:0]                  sel_err_reg, sel_err_next;

  // Flat view of all stock counters so the selection lookup can index them.
  logic [N_DRINKS*STOCK_W-1:0] stock_all;
  logic [N_DRINKS-1:0]         vend_dec;
  logic [N_DRINKS-1:0]         restock_hit;

  // Selection lookup. sel_hit is clear for codes that name no slot.
  logic                        sel_hit;
  logic [N_DRINKS-1:0]         sel_onehot;
  logic [BAL_W-1:0]            sel_price;
  logic [STOCK_W-1:0]          sel_stock;

  logic [BAL_W-1:0]            credit_base;
  logic [BAL_W:0]              coin_sum;
  logic                        coin_open;

  // Per-slot stock counters. A restock overrides a decrement in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_DRINKS; gi++) begin : g_slot
      logic [STOCK_W-1:0] stock_reg;

      assign restock_hit[gi] = restock_valid && (restock_id == SEL_W'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stock_reg <= STOCK_W'(STOCK_INIT);
        end else if (restock_hit[gi]) begin
          stock_reg <= STOCK_W'(STOCK_INIT);
        end else if (vend_dec[gi]) begin
          stock_reg <= stock_reg - 1'b1;
        end
      end

      assign stock_all[gi*STOCK_W +: STOCK_W] = stock_reg;
      assign sold_out[gi] = (stock_reg == '0);
    end
  endgenerate

  always_comb begin
    sel_hit    = 1'b0;
    sel_onehot = '0;
    sel_price  = '0;
    sel_stock  = '0;
    for (int i = 0; i < N_DRINKS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_hit       = 1'b1;
        sel_onehot[i] = 1'b1;
        sel_price     = PRICES[i*BAL_W +: BAL_W];
        sel_stock     = stock_all[i*STOCK_W +: STOCK_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= IDLE;
      balance_reg        <= '0;
      dispense_valid_reg <= 1'b0;
      dispense_id_reg    <= '0;
      change_valid_reg   <= 1'b0;
      change_amount_reg  <= '0;
      coin_reject_reg    <= 1'b0;
      sel_err_reg        <= 2'b00;
    end else begin
      state_reg          <= state_next;
      balance_reg        <= balance_next;
      dispense_valid_reg <= dispense_valid_next;
      dispense_id_reg    <= dispense_id_next;
      change_valid_reg   <= change_valid_next;
      change_amount_reg  <= change_amount_next;
      coin_reject_reg    <= coin_reject_next;
      sel_err_reg        <= sel_err_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    balance_next        = balance_reg;
    dispense_valid_next = dispense_valid_reg;
    dispense_id_next    = dispense_id_reg;
    change_valid_next   = change_valid_reg;
    change_amount_next  = change_amount_reg;
    coin_reject_next    = 1'b0;
    sel_err_next        = 2'b00;
    vend_dec            = '0;
    credit_base         = balance_reg;
    coin_sum            = '0;
    coin_open           = 1'b1;

    case (state_reg)
      IDLE: begin
        if (cancel) begin
          // Cancel outranks a selection in the same cycle.
          if (sel_valid) sel_err_next = 2'b11;
          if (balance_reg != '0) begin
            state_next         = CHANGE;
            change_valid_next  = 1'b1;
            change_amount_next = balance_reg;
            // The refund amount is frozen now, so no coin can join it.
            coin_open          = 1'b0;
          end
        end else if (sel_valid) begin
          if (!sel_hit) begin
            sel_err_next = 2'b11;
          end else if (sel_stock == '0) begin
            sel_err_next = 2'b01;
          end else if (balance_reg < sel_price) begin
            sel_err_next = 2'b10;
          end else begin
            // The price is checked against the credit held before this
            // cycle's coin. The coin is added after the price is deducted.
            credit_base         = balance_reg - sel_price;
            vend_dec            = sel_onehot;
            dispense_valid_next = 1'b1;
            dispense_id_next    = sel;
            state_next          = VEND;
          end
        end

        balance_next = credit_base;
        coin_sum     = {1'b0, credit_base} + (BAL_W+1)'(coin_value);
        if (coin_valid) begin
          if (coin_open && (coin_sum <= (BAL_W+1)'(MAX_BAL))) begin
            balance_next = coin_sum[BAL_W-1:0];
          end else begin
            coin_reject_next = 1'b1;
          end
        end
      end

      VEND: begin
        if (dispense_ready) begin
          dispense_valid_next = 1'b0;
          if ((AUTO_CHANGE != 0) && (balance_reg != '0)) begin
            state_next         = CHANGE;
            change_valid_next  = 1'b1;
            change_amount_next = balance_reg;
          end else begin
            state_next = IDLE;
          end
        end
      end

      CHANGE: begin
        if (change_ready) begin
          balance_next       = '0;
          change_valid_next  = 1'b0;
          change_amount_next = '0;
          state_next         = IDLE;
        end
      end

      default: begin
        // The unused encoding returns to IDLE and drops any pending request.
        state_next          = IDLE;
        dispense_valid_next = 1'b0;
        change_valid_next   = 1'b0;
      end
    endcase

    // While a transaction is in flight, the machine refuses coins and
    // selections. A cancel has no effect in this case.
    if (state_reg != IDLE) begin
      if (coin_valid) coin_reject_next = 1'b1;
      if (sel_valid)  sel_err_next     = 2'b11;
    end
  end

  assign balance        = balance_reg;
  assign dispense_valid = dispense_valid_reg;
  assign dispense_id    = dispense_id_reg;
  assign change_valid   = change_valid_reg;
  assign change_amount  = change_amount_reg;
  assign coin_reject    = coin_reject_reg;
  assign sel_err        = sel_err_reg;

endmodule

// File: tb/tb_vending_machine_multi.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_multi
//   Directed bench for vending_machine_multi. The DUT is built with three slots
//   priced 4/3/5. Each slot starts with a stock of 2, and auto change is on.
//   Each row of the vector table drives the inputs for one clock cycle. It
//   also gives the register values expected just after that clock edge.
//   Hand-written sequences cover the long change stall and an asynchronous
//   reset in the middle of a vend.
// ---------------------------------------------------------------------------
module tb_vending_machine_multi;

  logic       clk;
  logic       reset_n;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       restock_valid;
  logic [1:0] restock_id;
  logic       dispense_valid;
  logic [1:0] dispense_id;
  logic       dispense_ready;
  logic       change_valid;
  logic [3:0] change_amount;
  logic       change_ready;
  logic [3:0] balance;
  logic       coin_reject;
  logic [1:0] sel_err;
  logic [2:0] sold_out;

  int n_cmp  = 0;
  int n_fail = 0;

  vending_machine_multi #(
    .N_DRINKS(3), .SEL_W(2), .COIN_W(2), .BAL_W(4), .MAX_BAL(15),
    .PRICES(12'h534), .STOCK_W(4), .STOCK_INIT(2), .AUTO_CHANGE(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .restock_valid(restock_valid), .restock_id(restock_id),
    .dispense_valid(dispense_valid), .dispense_id(dispense_id),
    .dispense_ready(dispense_ready),
    .change_valid(change_valid), .change_amount(change_amount),
    .change_ready(change_ready),
    .balance(balance), .coin_reject(coin_reject), .sel_err(sel_err),
    .sold_out(sold_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cv; int cval; int sv; int sl; int cn; int rv; int rid; int dr; int cr;
    int bal; int dv; int id; int chv; int amt; int rej; int err; int so;
  } vec_t;

  vec_t vq[$];
  localparam int STALL_AFTER = 29;

  function automatic void add(input vec_t v);
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clear_inputs();
    coin_valid = 1'b0; coin_value = 2'd0; sel_valid = 1'b0; sel = 2'd0;
    cancel = 1'b0; restock_valid = 1'b0; restock_id = 2'd0;
    dispense_ready = 1'b0; change_ready = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vq[i];
    coin_valid     = 1'(v.cv);  coin_value = 2'(v.cval);
    sel_valid      = 1'(v.sv);  sel        = 2'(v.sl);
    cancel         = 1'(v.cn);
    restock_valid  = 1'(v.rv);  restock_id = 2'(v.rid);
    dispense_ready = 1'(v.dr);  change_ready = 1'(v.cr);
    @(posedge clk);
    #1;
    check($sformatf("v%0d.balance", i),        int'(balance),        v.bal);
    check($sformatf("v%0d.dispense_valid", i), int'(dispense_valid), v.dv);
    if (v.dv != 0) check($sformatf("v%0d.dispense_id", i), int'(dispense_id), v.id);
    check($sformatf("v%0d.change_valid", i),   int'(change_valid),   v.chv);
    if (v.chv != 0) check($sformatf("v%0d.change_amount", i), int'(change_amount), v.amt);
    check($sformatf("v%0d.coin_reject", i),    int'(coin_reject),    v.rej);
    check($sformatf("v%0d.sel_err", i),        int'(sel_err),        v.err);
    check($sformatf("v%0d.sold_out", i),       int'(sold_out),       v.so);
    $display("vec %0d: bal=%0d dv=%0d id=%0d cv=%0d amt=%0d rej=%0d err=%0d so=%0d",
             i, balance, dispense_valid, dispense_id, change_valid, change_amount,
             coin_reject, sel_err, sold_out);
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();

    //    cv cval sv sel cn rv rid dr cr | bal dv id chv amt rej err so
    // Coins 2,2, then vend slot 1 (price 3). One unit of change comes back.
    add('{1,2, 0,0, 0, 0,0, 0,0,   2, 0,0, 0,0,  0,0, 0});
    add('{1,2, 0,0, 0, 0,0, 0,0,   4, 0,0, 0,0,  0,0, 0});
    add('{0,0, 1,1, 0, 0,0, 0,0,   1, 1,1, 0,0,  0,0, 0});
    add('{0,0, 0,0, 0, 0,0, 0,0,   1, 1,1, 0,0,  0,0, 0});
    add('{0,0, 0,0, 0, 0,0, 1,0,   1, 0,0, 1,1,  0,0, 0});
    add('{0,0, 0,0, 0, 0,0, 0,1,   0, 0,0, 0,0,  0,0, 0});
    // Credit ceiling: reach 14, reject 2, accept 1 to 15, reject 1, refund.
    add('{1,3, 0,0, 0, 0,0, 0,0,   3, 0,0, 0,0,  0,0, 0});
    add('{1,3, 0,0, 0, 0,0, 0,0,   6, 0,0, 0,0,  0,0, 0});
    add('{1,3, 0,0, 0, 0,0, 0,0,   9, 0,0, 0,0,  0,0, 0});
    add('{1,3, 0,0, 0, 0,0, 0,0,  12, 0,0, 0,0,  0,0, 0});
    add('{1,2, 0,0, 0, 0,0, 0,0,  14, 0,0, 0,0,  0,0, 0});
    add('{1,2, 0,0, 0, 0,0, 0,0,  14, 0,0, 0,0,  1,0, 0});
    add('{1,1, 0,0, 0, 0,0, 0,0,  15, 0,0, 0,0,  0,0, 0});
    add('{1,1, 0,0, 0, 0,0, 0,0,  15, 0,0, 0,0,  1,0, 0});
    add('{0,0, 0,0, 1, 0,0, 0,0,  15, 0,0, 1,15, 0,0, 0});
    add('{0,0, 0,0, 0, 0,0, 0,1,   0, 0,0, 0,0,  0,0, 0});
    // Slot 2 (price 5) is vended twice until it is empty, then restocked.
    add('{1,3, 0,0, 0, 0,0, 0,0,   3, 0,0, 0,0,  0,0, 0});
    add('{1,2, 0,0, 0, 0,0, 0,0,   5, 0,0, 0,0,  0,0, 0});
    add('{0,0, 1,2, 0, 0,0, 0,0,   0, 1,2, 0,0,  0,0, 0});
    add('{0,0, 0,0, 0, 0,0, 1,0,   0, 0,0, 0,0,  0,0, 0});
    add('{1,3, 0,0, 0, 0,0, 0,0,   3, 0,0, 0,0,  0,0, 0});
    add('{1,2, 0,0, 0, 0,0, 0,0,   5, 0,0, 0,0,  0,0, 0});
    add('{0,0, 1,2, 0, 0,0, 0,0,   0, 1,2, 0,0,  0,0, 4});
    add('{0,0, 0,0, 0, 0,0, 1,0,   0, 0,0, 0,0,  0,0, 4});
    add('{0,0, 1,2, 0, 0,0, 0,0,   0, 0,0, 0,0,  0,1, 4});
    add('{0,0, 0,0, 0, 0,0, 0,0,   0, 0,0, 0,0,  0,0, 4});
    add('{0,0, 0,0, 0, 1,2, 0,0,   0, 0,0, 0,0,  0,0, 0});
    // Insufficient credit for slot 0 (price 4), then cancel. The stall follows.
    add('{1,2, 0,0, 0, 0,0, 0,0,   2, 0,0, 0,0,  0,0, 0});
    add('{0,0, 1,0, 0, 0,0, 0,0,   2, 0,0, 0,0,  0,2, 0});
    add('{0,0, 0,0, 1, 0,0, 0,0,   2, 0,0, 1,2,  0,0, 0});
    // Coin and selection arrive in the same cycle. Then coin, sel and cancel
    // arrive while a vend is pending.
    add('{1,3, 0,0, 0, 0,0, 0,0,   3, 0,0, 0,0,  0,0, 0});
    add('{1,2, 1,1, 0, 0,0, 0,0,   2, 1,1, 0,0,  0,0, 2});
    add('{1,1, 0,0, 0, 0,0, 0,0,   2, 1,1, 0,0,  1,0, 2});
    add('{0,0, 1,0, 0, 0,0, 0,0,   2, 1,1, 0,0,  0,3, 2});
    add('{0,0, 0,0, 1, 0,0, 0,0,   2, 1,1, 0,0,  0,0, 2});
    add('{0,0, 0,0, 0, 0,0, 1,0,   2, 0,0, 1,2,  0,0, 2});
    add('{0,0, 0,0, 0, 0,0, 0,1,   0, 0,0, 0,0,  0,0, 2});
    // Cancel at zero credit, a sold-out slot, an invalid code, an
    // out-of-range restock, and cancel together with a selection.
    add('{0,0, 0,0, 1, 0,0, 0,0,   0, 0,0, 0,0,  0,0, 2});
    add('{0,0, 1,1, 0, 0,0, 0,0,   0, 0,0, 0,0,  0,1, 2});
    add('{0,0, 1,3, 0, 0,0, 0,0,   0, 0,0, 0,0,  0,3, 2});
    add('{0,0, 0,0, 0, 1,3, 0,0,   0, 0,0, 0,0,  0,0, 2});
    add('{1,1, 1,0, 1, 0,0, 0,0,   1, 0,0, 0,0,  0,3, 2});
    add('{0,0, 0,0, 1, 0,0, 0,0,   1, 0,0, 1,1,  0,0, 2});
    add('{0,0, 0,0, 0, 0,0, 0,1,   0, 0,0, 0,0,  0,0, 2});
    add('{0,0, 0,0, 0, 1,1, 0,0,   0, 0,0, 0,0,  0,0, 0});
    // A restock of slot 1 in the same cycle as its last-unit vend wins.
    add('{1,3, 0,0, 0, 0,0, 0,0,   3, 0,0, 0,0,  0,0, 0});
    add('{0,0, 1,1, 0, 0,0, 0,0,   0, 1,1, 0,0,  0,0, 0});
    add('{0,0, 0,0, 0, 0,0, 1,0,   0, 0,0, 0,0,  0,0, 0});
    add('{1,3, 0,0, 0, 0,0, 0,0,   3, 0,0, 0,0,  0,0, 0});
    add('{0,0, 1,1, 0, 1,1, 0,0,   0, 1,1, 0,0,  0,0, 0});
    add('{0,0, 0,0, 0, 0,0, 1,0,   0, 0,0, 0,0,  0,0, 0});
    // Slot 1 is drained back to empty. The final vend is left pending.
    add('{1,3, 0,0, 0, 0,0, 0,0,   3, 0,0, 0,0,  0,0, 0});
    add('{0,0, 1,1, 0, 0,0, 0,0,   0, 1,1, 0,0,  0,0, 0});
    add('{0,0, 0,0, 0, 0,0, 1,0,   0, 0,0, 0,0,  0,0, 0});
    add('{1,3, 0,0, 0, 0,0, 0,0,   3, 0,0, 0,0,  0,0, 0});
    add('{0,0, 1,1, 0, 0,0, 0,0,   0, 1,1, 0,0,  0,0, 2});

    // Reset values
    #12;
    reset_n = 1'b1;
    check("reset.balance",        int'(balance),        0);
    check("reset.dispense_valid", int'(dispense_valid), 0);
    check("reset.dispense_id",    int'(dispense_id),    0);
    check("reset.change_valid",   int'(change_valid),   0);
    check("reset.change_amount",  int'(change_amount),  0);
    check("reset.coin_reject",    int'(coin_reject),    0);
    check("reset.sel_err",        int'(sel_err),        0);
    check("reset.sold_out",       int'(sold_out),       0);
    $display("reset: bal=%0d dv=%0d cv=%0d so=%0d", balance, dispense_valid, change_valid, sold_out);

    for (int i = 0; i <= STALL_AFTER; i++) run_vec(i);

    // The hopper stalls for 5 cycles. The refund request must hold steady.
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d.change_valid", k),  int'(change_valid),  1);
      check($sformatf("stall%0d.change_amount", k), int'(change_amount), 2);
      check($sformatf("stall%0d.balance", k),       int'(balance),       2);
      $display("stall %0d: cv=%0d amt=%0d bal=%0d", k, change_valid, change_amount, balance);
    end
    change_ready = 1'b1;
    @(posedge clk);
    #1;
    change_ready = 1'b0;
    check("stall.accept.change_valid", int'(change_valid), 0);
    check("stall.accept.balance",      int'(balance),      0);
    $display("stall accept: cv=%0d bal=%0d", change_valid, balance);

    for (int i = STALL_AFTER + 1; i < vq.size(); i++) run_vec(i);

    // Reset asserted between clock edges while a vend is pending.
    clear_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset.dispense_valid", int'(dispense_valid), 0);
    check("midreset.dispense_id",    int'(dispense_id),    0);
    check("midreset.balance",        int'(balance),        0);
    check("midreset.sold_out",       int'(sold_out),       0);
    check("midreset.change_valid",   int'(change_valid),   0);
    $display("midreset: dv=%0d bal=%0d so=%0d", dispense_valid, balance, sold_out);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    sel_valid = 1'b1;
    sel       = 2'd3;
    @(posedge clk);
    #1;
    clear_inputs();
    check("post.sel3.sel_err", int'(sel_err), 3);
    $display("post sel3: err=%0d", sel_err);

    dispense_ready = 1'b1;
    @(posedge clk);
    #1;
    clear_inputs();
    check("post.aborted.dispense_valid", int'(dispense_valid), 0);
    check("post.aborted.change_valid",   int'(change_valid),   0);
    $display("post abort: dv=%0d cv=%0d", dispense_valid, change_valid);

    coin_valid = 1'b1;
    coin_value = 2'd3;
    @(posedge clk);
    #1;
    clear_inputs();
    check("post.coin.balance", int'(balance), 3);
    $display("post coin: bal=%0d", balance);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
